bcd_display_scan: RTL
=====================

Name: bcd_display_scan

Overview:
- Downstream consumer of the cascaded mod-10 digit counters: takes four 4-bit BCD digits and drives a 4-digit multiplexed seven-segment display.
- Snapshots all digits once per frame so a digit carry mid-scan cannot tear the display.
- Scans one digit at a time at a programmable refresh rate, with BCD-to-segment decode, invalid-code indication and optional leading-zero blanking.
- Sits between the counter chain and the board display pins.

Parameters:
- DIV, 50000, clock cycles each digit stays lit (must be >= 2); prescaler width is $clog2(DIV).
- SEG_ACTIVE_LOW, 1, 1: seg/dp/an driven active-low; 0: active-high.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-low reset (asserted at 0)
- en  in  1  1: scanning runs; 0: prescaler and digit index hold, all anodes off
- blank_lz  in  1  1: blank leading zeros in the snapshot
- digits  in  16  BCD digits; [3:0] units (digit 0) ... [15:12] thousands (digit 3)
- dp_in  in  4  decimal point request per digit, bit i = digit i
- seg  out  7  segments {g,f,e,d,c,b,a}, registered
- dp  out  1  decimal point of the active digit, registered
- an  out  4  one-hot digit enable, registered
- frame_start  out  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Reset: asynchronous on rst=0.
  - Prescaler = 0, digit index = 0, snapshot digits = 0, snapshot dp = 0, snapshot blank_lz = 0.
  - seg, dp, an = inactive level (all 1 if SEG_ACTIVE_LOW, else all 0); frame_start = 0.
- Prescaler: counts 0..DIV-1 while en=1, then wraps to 0. tick = (prescaler == DIV-1) && en.
- Digit index: 2-bit, advances on tick, 3 wraps to 0.
- Snapshot:
  - On a tick where index == 3 (index about to become 0), capture digits, dp_in and blank_lz into the snapshot registers. frame_start = 1 in the following cycle only.
  - Inputs changing at any other time have no visible effect until the next frame.
  - First frame after reset shows zeros (blanked per the reset snapshot blank_lz = 0, so "0000").
- Output register latency: seg/dp/an reflect the current index and snapshot one cycle after the index register updates. Each digit is lit for exactly DIV cycles.
- Decode (active-high view, before polarity):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F (bit order {g..a}).
  - Codes 10..15 show a dash: g only = 40.
- Leading-zero blanking: when snapshot blank_lz = 1, digit i (i = 3..1) is blanked if it and every higher digit equal 0.
  - Digit 0 is never blanked.
  - Blanked digit: seg all off, dp still shown if requested, an still enabled.
  - An invalid code (10..15) counts as nonzero.
- en = 0:
  - an goes inactive in the next cycle; seg/dp are don't-care but must be inactive.
  - Prescaler, index and snapshot hold. Scanning resumes from the held state when en returns to 1.
- Polarity: if SEG_ACTIVE_LOW = 1, seg, dp and an are bitwise inverted at the output register (an active digit = 0).
- Reset mid-frame: outputs go inactive immediately (asynchronous). Scanning restarts at digit 0 with the zero snapshot.

Test Plan:
- DIV=4, SEG_ACTIVE_LOW=1, rst released, en=1, digits=16'h1234, dp_in=0 -> first frame shows 0 (seg=7'h40 on each an). After frame_start: an=1110 seg=7'h19 (4), an=1101 seg=7'h30 (3), an=1011 seg=7'h24 (2), an=0111 seg=7'h79 (1), each held exactly 4 cycles.
- digits=16'h0007, blank_lz=1 after snapshot -> digits 3..1 seg=7'h7F (blank) with an active, digit 0 seg=7'h78. Same input with blank_lz=0 -> digits 3..1 show 0 (7'h40).
- digits changed from 16'h0009 to 16'h0010 mid-frame -> displayed digits stay 0009 until the next frame_start, then 0010. No mixed frame appears.
- digits=16'h00A0 (invalid code), blank_lz=1, dp_in=4'b0010 -> digit 1 seg=7'h3F (dash, active-low) with dp=0. Digit 2 is blanked, digit 3 is blanked. Digit 0 shows 0.
- en=0 held 20 cycles mid-scan -> an=4'b1111 from the next cycle, prescaler and index frozen. On en=1, the same digit resumes with its remaining count.
- rst=0 asserted asynchronously between clock edges during digit 2 -> seg=7'h7F, an=4'hF, dp=1 immediately. After release, digit 0 is lit first and shows 0.

Source files
------------

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed seven-segment driver for BCD counter outputs.
// Digits are captured once per frame so a carry during the scan cannot tear the display.
module bcd_display_scan #(
    parameter int DIV            = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        blank_lz,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_start
);
    localparam int            PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX    = PW'(DIV - 1);
    localparam logic [6:0]    SEG_INV = {7{SEG_ACTIVE_LOW}};
    localparam logic [3:0]    AN_INV  = {4{SEG_ACTIVE_LOW}};

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_dig_q, snap_dig_d;
    logic [3:0]    snap_dp_q, snap_dp_d;
    logic          snap_lz_q, snap_lz_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          fs_q, fs_d;

    logic          tick;
    logic [3:0]    nib;
    logic          blank;
    logic [6:0]    seg_raw;
    logic [6:0]    seg_act;
    logic          dp_act;
    logic [3:0]    an_act;

    always_comb begin
        tick       = en && (presc_q == PMAX);
        presc_d    = presc_q;
        idx_d      = idx_q;
        snap_dig_d = snap_dig_q;
        snap_dp_d  = snap_dp_q;
        snap_lz_d  = snap_lz_q;
        fs_d       = tick && (idx_q == 2'd3);

        if (en) presc_d = tick ? '0 : presc_q + 1'b1;
        if (tick) idx_d = idx_q + 1'b1;
        if (fs_d) begin
            snap_dig_d = digits;
            snap_dp_d  = dp_in;
            snap_lz_d  = blank_lz;
        end

        nib = snap_dig_q[{idx_q, 2'b00} +: 4];

        // A digit is a leading zero when it and everything above it is zero.
        case (idx_q)
            2'd3:    blank = snap_lz_q && (snap_dig_q[15:12] == 4'd0);
            2'd2:    blank = snap_lz_q && (snap_dig_q[15:8]  == 8'd0);
            2'd1:    blank = snap_lz_q && (snap_dig_q[15:4]  == 12'd0);
            default: blank = 1'b0;
        endcase

        case (nib)
            4'd0:    seg_raw = 7'h3F;
            4'd1:    seg_raw = 7'h06;
            4'd2:    seg_raw = 7'h5B;
            4'd3:    seg_raw = 7'h4F;
            4'd4:    seg_raw = 7'h66;
            4'd5:    seg_raw = 7'h6D;
            4'd6:    seg_raw = 7'h7D;
            4'd7:    seg_raw = 7'h07;
            4'd8:    seg_raw = 7'h7F;
            4'd9:    seg_raw = 7'h6F;
            default: seg_raw = 7'h40;
        endcase

        seg_act = 7'h00;
        dp_act  = 1'b0;
        an_act  = 4'b0000;
        if (en) begin
            seg_act = blank ? 7'h00 : seg_raw;
            dp_act  = snap_dp_q[idx_q];
            an_act  = 4'b0001 << idx_q;
        end

        seg_d = seg_act ^ SEG_INV;
        dp_d  = dp_act ^ SEG_ACTIVE_LOW;
        an_d  = an_act ^ AN_INV;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q    <= '0;
            idx_q      <= 2'd0;
            snap_dig_q <= 16'd0;
            snap_dp_q  <= 4'd0;
            snap_lz_q  <= 1'b0;
            seg_q      <= SEG_INV;
            dp_q       <= SEG_ACTIVE_LOW;
            an_q       <= AN_INV;
            fs_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            snap_dig_q <= snap_dig_d;
            snap_dp_q  <= snap_dp_d;
            snap_lz_q  <= snap_lz_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            fs_q       <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp          = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;
endmodule
